// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm-clock adjust path.
// Contents: field widths and moduli for hours/minutes, the adjust FSM state
// type, and wrap_step(), a single up/down step with modular wrap.
package alarm_pkg;

  localparam int unsigned HOUR_W   = 5;
  localparam int unsigned MIN_W    = 6;
  localparam int unsigned HOUR_MOD = 24;
  localparam int unsigned MIN_MOD  = 60;

  typedef enum logic [1:0] {StIdle, StLoad, StEdit} adj_state_e;

  // One step with wrap. An out-of-range value (loaded unchanged from the
  // inputs) is pulled back into range by the first step in either direction.
  function automatic logic [MIN_W-1:0] wrap_step(input logic [MIN_W-1:0] value,
                                                  input logic [MIN_W-1:0] modulus,
                                                  input logic             up);
    logic [MIN_W-1:0] res;
    if (up) begin
      res = (value >= modulus - MIN_W'(1)) ? '0 : value + MIN_W'(1);
    end else begin
      res = (value == '0 || value >= modulus) ? modulus - MIN_W'(1) : value - MIN_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Edge detect plus hold/auto-repeat for one debounced button.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   btn        : debounced button level
//   clear      : suppress stepping and drop the repeat timer
//   rise       : combinational rising-edge indication
//   step       : one-cycle step pulse (edge, then HOLD_CYCLES, then every REPEAT_CYCLES)
module btn_repeat #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clear,
  output logic rise,
  output logic step
);

  logic        btn_q;
  logic        armed_q;      // timer runs only after an accepted edge step
  logic        repeating_q;  // past the initial hold period
  logic [31:0] cnt_q;        // cycles since the last step
  logic [31:0] limit;

  assign rise  = btn & ~btn_q;
  assign limit = repeating_q ? 32'(REPEAT_CYCLES) : 32'(HOLD_CYCLES);
  assign step  = ~clear & btn & (rise | (armed_q & (cnt_q == limit)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q       <= 1'b0;
      armed_q     <= 1'b0;
      repeating_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      btn_q <= btn;
      if (clear || !btn) begin
        armed_q     <= 1'b0;
        repeating_q <= 1'b0;
        cnt_q       <= '0;
      end else if (step) begin
        armed_q     <= 1'b1;
        repeating_q <= ~rise;
        cnt_q       <= 32'd1;
      end else if (armed_q) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_adjust.sv
// User-adjust controller for clock time and NUM_ALARMS alarm times.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   enable                      : adjust mode request (level)
//   btn_center/left/right/up/down : debounced button levels
//   in_time_*, in_alarm_*       : current values (alarm k at [W*k +: W])
//   time_*_out, alarm_*_out     : held/edited values, same packing
//   sel_tens, sel_units         : BCD digits of the selected field
//   field_led                   : one-hot selected field while editing
//   adjusted                    : bit 0 time differs from input, bit k+1 alarm k
//   editing                     : high while in edit
module multi_alarm_adjust
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS     = 2,
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           btn_center,
  input  logic                           btn_left,
  input  logic                           btn_right,
  input  logic                           btn_up,
  input  logic                           btn_down,
  input  logic [HOUR_W-1:0]              in_time_hours,
  input  logic [MIN_W-1:0]               in_time_minutes,
  input  logic [HOUR_W*NUM_ALARMS-1:0]   in_alarm_hours,
  input  logic [MIN_W*NUM_ALARMS-1:0]    in_alarm_minutes,
  output logic [HOUR_W-1:0]              time_hours_out,
  output logic [MIN_W-1:0]               time_minutes_out,
  output logic [HOUR_W*NUM_ALARMS-1:0]   alarm_hours_out,
  output logic [MIN_W*NUM_ALARMS-1:0]    alarm_minutes_out,
  output logic [2:0]                     sel_tens,
  output logic [3:0]                     sel_units,
  output logic [2*(NUM_ALARMS+1)-1:0]    field_led,
  output logic [NUM_ALARMS:0]            adjusted,
  output logic                           editing
);

  localparam int unsigned NUM_FIELDS = 2 * (NUM_ALARMS + 1);
  localparam logic [3:0]  FIELD_MAX  = 4'(NUM_FIELDS - 1);

  adj_state_e        state_q;
  logic [3:0]        field_q;
  logic [HOUR_W-1:0] time_h_q;
  logic [MIN_W-1:0]  time_m_q;
  logic [HOUR_W-1:0] alarm_h_q [NUM_ALARMS];
  logic [MIN_W-1:0]  alarm_m_q [NUM_ALARMS];
  logic [31:0]       idle_cnt_q;
  logic              center_q, left_q, right_q;

  logic center_rise, left_rise, right_rise, up_rise, down_rise, any_rise;
  logic up_step, down_step, rep_clear;
  logic [MIN_W-1:0] sel_val, sel_mod, stepped;

  assign center_rise = btn_center & ~center_q;
  assign left_rise   = btn_left & ~left_q;
  assign right_rise  = btn_right & ~right_q;
  assign any_rise    = center_rise | left_rise | right_rise | up_rise | down_rise;

  // Both up and down held cancel each other and drop both repeat timers.
  assign rep_clear = (btn_up & btn_down) | (state_q != StEdit);

  btn_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .clear(rep_clear),
    .rise (up_rise),
    .step (up_step)
  );

  btn_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .clear(rep_clear),
    .rise (down_rise),
    .step (down_step)
  );

  // Selected field value; even fields are hours, odd fields are minutes.
  always_comb begin
    sel_val = '0;
    if (field_q == 4'd0) sel_val = MIN_W'(time_h_q);
    if (field_q == 4'd1) sel_val = time_m_q;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (field_q == 4'(2 + 2 * k)) sel_val = MIN_W'(alarm_h_q[k]);
      if (field_q == 4'(3 + 2 * k)) sel_val = alarm_m_q[k];
    end
    sel_mod = field_q[0] ? MIN_W'(MIN_MOD) : MIN_W'(HOUR_MOD);
    stepped = wrap_step(sel_val, sel_mod, up_step);
  end

  assign sel_tens  = 3'(sel_val / MIN_W'(10));
  assign sel_units = 4'(sel_val % MIN_W'(10));
  assign field_led = editing ? (NUM_FIELDS'(1) << field_q) : '0;

  assign time_hours_out   = time_h_q;
  assign time_minutes_out = time_m_q;
  for (genvar gk = 0; gk < NUM_ALARMS; gk++) begin : g_pack
    assign alarm_hours_out[HOUR_W*gk +: HOUR_W] = alarm_h_q[gk];
    assign alarm_minutes_out[MIN_W*gk +: MIN_W] = alarm_m_q[gk];
  end

  always_comb begin
    adjusted    = '0;
    adjusted[0] = (time_h_q != in_time_hours) | (time_m_q != in_time_minutes);
    for (int k = 0; k < NUM_ALARMS; k++) begin
      adjusted[k+1] = (alarm_h_q[k] != in_alarm_hours[HOUR_W*k +: HOUR_W]) |
                      (alarm_m_q[k] != in_alarm_minutes[MIN_W*k +: MIN_W]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      field_q    <= '0;
      time_h_q   <= '0;
      time_m_q   <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        alarm_h_q[k] <= '0;
        alarm_m_q[k] <= '0;
      end
      idle_cnt_q <= '0;
      center_q   <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      editing    <= 1'b0;
    end else begin
      center_q <= btn_center;
      left_q   <= btn_left;
      right_q  <= btn_right;
      unique case (state_q)
        StIdle: begin
          if (enable) state_q <= StLoad;
        end
        StLoad: begin
          time_h_q <= in_time_hours;
          time_m_q <= in_time_minutes;
          for (int k = 0; k < NUM_ALARMS; k++) begin
            alarm_h_q[k] <= in_alarm_hours[HOUR_W*k +: HOUR_W];
            alarm_m_q[k] <= in_alarm_minutes[MIN_W*k +: MIN_W];
          end
          field_q    <= '0;
          idle_cnt_q <= '0;
          state_q    <= StEdit;
          editing    <= 1'b1;
        end
        StEdit: begin
          if (!enable) begin
            state_q <= StIdle;
            editing <= 1'b0;
          end else if (center_rise) begin
            state_q <= StLoad;
            editing <= 1'b0;
          end else begin
            if (any_rise) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == TIMEOUT_CYCLES - 1) begin
              state_q <= StIdle;
              editing <= 1'b0;
            end else begin
              idle_cnt_q <= idle_cnt_q + 32'd1;
            end
            if (right_rise) begin
              field_q <= (field_q == FIELD_MAX) ? 4'd0 : field_q + 4'd1;
            end else if (left_rise) begin
              field_q <= (field_q == 4'd0) ? FIELD_MAX : field_q - 4'd1;
            end else if (up_step || down_step) begin
              if (field_q == 4'd0) time_h_q <= stepped[HOUR_W-1:0];
              if (field_q == 4'd1) time_m_q <= stepped;
              for (int k = 0; k < NUM_ALARMS; k++) begin
                if (field_q == 4'(2 + 2 * k)) alarm_h_q[k] <= stepped[HOUR_W-1:0];
                if (field_q == 4'(3 + 2 * k)) alarm_m_q[k] <= stepped;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_alarm_adjust.sv
// Self-checking bench for multi_alarm_adjust (NUM_ALARMS=2, short timers).
module tb_multi_alarm_adjust;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic        btn_center, btn_left, btn_right, btn_up, btn_down;
  logic [4:0]  in_time_hours;
  logic [5:0]  in_time_minutes;
  logic [9:0]  in_alarm_hours;
  logic [11:0] in_alarm_minutes;
  logic [4:0]  time_hours_out;
  logic [5:0]  time_minutes_out;
  logic [9:0]  alarm_hours_out;
  logic [11:0] alarm_minutes_out;
  logic [2:0]  sel_tens;
  logic [3:0]  sel_units;
  logic [5:0]  field_led;
  logic [2:0]  adjusted;
  logic        editing;

  multi_alarm_adjust #(
    .NUM_ALARMS    (2),
    .HOLD_CYCLES   (4),
    .REPEAT_CYCLES (2),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .btn_center       (btn_center),
    .btn_left         (btn_left),
    .btn_right        (btn_right),
    .btn_up           (btn_up),
    .btn_down         (btn_down),
    .in_time_hours    (in_time_hours),
    .in_time_minutes  (in_time_minutes),
    .in_alarm_hours   (in_alarm_hours),
    .in_alarm_minutes (in_alarm_minutes),
    .time_hours_out   (time_hours_out),
    .time_minutes_out (time_minutes_out),
    .alarm_hours_out  (alarm_hours_out),
    .alarm_minutes_out(alarm_minutes_out),
    .sel_tens         (sel_tens),
    .sel_units        (sel_units),
    .field_led        (field_led),
    .adjusted         (adjusted),
    .editing          (editing)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  typedef struct {
    string      name;
    logic [2:0] tens;
    logic [3:0] units;
    logic [5:0] led;
    logic [2:0] adj;
    logic       edit;
  } exp_t;

  typedef struct {
    logic [4:0] btn;
    logic [2:0] tens;
    logic [3:0] units;
    logic [5:0] led;
    logic [2:0] adj;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input logic [2:0] tens, input logic [3:0] units,
                            input logic [5:0] led, input logic [2:0] adj, input logic edit);
    exp_t e;
    e.name  = name;
    e.tens  = tens;
    e.units = units;
    e.led   = led;
    e.adj   = adj;
    e.edit  = edit;
    sb.push_back(e);
  endtask

  // Advance one clock; compare the oldest pending expectation just after the edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({sel_tens, sel_units, field_led, adjusted, editing} !==
          {e.tens, e.units, e.led, e.adj, e.edit}) begin
        failures++;
        $display("FAIL %s: got tens=%0d units=%0d led=%b adj=%b edit=%b expected tens=%0d units=%0d led=%b adj=%b edit=%b",
                 e.name, sel_tens, sel_units, field_led, adjusted, editing,
                 e.tens, e.units, e.led, e.adj, e.edit);
      end
    end
  endtask

  task automatic set_btn(input logic [4:0] b);
    {btn_center, btn_left, btn_right, btn_up, btn_down} = b;
  endtask

  task automatic press(input logic [4:0] b);
    set_btn(b);
    tick();
    set_btn(5'b0);
    tick();
  endtask

  initial begin
    int v;
    // Starting point: f=0, time 12:34, alarm0 06:45, alarm1 23:00.
    vecs[0]  = '{B_U,       3'd1, 4'd3, 6'b000001, 3'b001};
    vecs[1]  = '{B_D,       3'd1, 4'd2, 6'b000001, 3'b000};
    vecs[2]  = '{B_R,       3'd3, 4'd4, 6'b000010, 3'b000};
    vecs[3]  = '{B_D,       3'd3, 4'd3, 6'b000010, 3'b001};
    vecs[4]  = '{B_R,       3'd0, 4'd6, 6'b000100, 3'b001};
    vecs[5]  = '{B_L,       3'd3, 4'd3, 6'b000010, 3'b001};
    vecs[6]  = '{B_L,       3'd1, 4'd2, 6'b000001, 3'b001};
    vecs[7]  = '{B_L,       3'd0, 4'd0, 6'b100000, 3'b001};
    vecs[8]  = '{B_D,       3'd5, 4'd9, 6'b100000, 3'b101};
    vecs[9]  = '{B_R,       3'd1, 4'd2, 6'b000001, 3'b101};
    vecs[10] = '{B_R,       3'd3, 4'd3, 6'b000010, 3'b101};
    vecs[11] = '{B_U | B_D, 3'd3, 4'd3, 6'b000010, 3'b101};

    reset            = 1'b1;
    enable           = 1'b0;
    set_btn(5'b0);
    in_time_hours    = 5'd12;
    in_time_minutes  = 6'd34;
    in_alarm_hours   = {5'd23, 5'd6};
    in_alarm_minutes = {6'd0, 6'd45};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_editing", editing, 0);
    chk("reset_led", field_led, 0);
    chk("reset_sel", {sel_tens, sel_units}, 0);
    chk("reset_adjusted", adjusted, 3'b111);
    chk("reset_time_hours", time_hours_out, 0);
    reset = 1'b0;

    enable = 1'b1;
    expect_out("load_cycle", 3'd0, 4'd0, 6'b0, 3'b111, 1'b0);
    tick();
    expect_out("edit_entry", 3'd1, 4'd2, 6'b000001, 3'b000, 1'b1);
    tick();

    for (int i = 0; i < 12; i++) begin
      expect_out($sformatf("vec%0d", i), vecs[i].tens, vecs[i].units, vecs[i].led,
                 vecs[i].adj, 1'b1);
      press(vecs[i].btn);
    end
    chk("alarm_min_pack", alarm_minutes_out, {6'd59, 6'd45});

    // Center with right in the same cycle: reload wins, edits discarded.
    expect_out("center_right_load", 3'd3, 4'd3, 6'b0, 3'b101, 1'b0);
    set_btn(B_C | B_R);
    tick();
    set_btn(5'b0);
    expect_out("center_right_edit", 3'd1, 4'd2, 6'b000001, 3'b000, 1'b1);
    tick();

    // Hour wrap up, minute wrap down.
    in_time_hours   = 5'd23;
    in_time_minutes = 6'd0;
    set_btn(B_C);
    tick();
    set_btn(5'b0);
    expect_out("reload_23", 3'd2, 4'd3, 6'b000001, 3'b000, 1'b1);
    tick();
    expect_out("hour_wrap_up", 3'd0, 4'd0, 6'b000001, 3'b001, 1'b1);
    set_btn(B_U);
    tick();
    chk("hour_wrap_value", time_hours_out, 0);
    set_btn(5'b0);
    tick();
    expect_out("to_minutes", 3'd0, 4'd0, 6'b000010, 3'b001, 1'b1);
    press(B_R);
    expect_out("min_wrap_down", 3'd5, 4'd9, 6'b000010, 3'b001, 1'b1);
    press(B_D);
    chk("min_wrap_value", time_minutes_out, 59);

    // Auto-repeat from 58: steps at edge, +4, +6, +8.
    in_time_minutes = 6'd58;
    press(B_C);
    expect_out("repeat_start", 3'd5, 4'd8, 6'b000010, 3'b000, 1'b1);
    press(B_R);
    set_btn(B_U);
    for (int i = 0; i < 10; i++) begin
      v = (i < 4) ? 59 : (i < 6) ? 0 : (i < 8) ? 1 : 2;
      expect_out($sformatf("repeat_%0d", i), 3'(v / 10), 4'(v % 10), 6'b000010, 3'b001, 1'b1);
      tick();
    end
    set_btn(5'b0);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("release_%0d", i), 3'd0, 4'd2, 6'b000010, 3'b001, 1'b1);
      tick();
    end

    // enable dropped while up is held: leave edit, no further steps.
    press(B_C);
    expect_out("disable_step", 3'd0, 4'd0, 6'b000001, 3'b001, 1'b1);
    set_btn(B_U);
    tick();
    enable = 1'b0;
    expect_out("disable_idle", 3'd0, 4'd0, 6'b000000, 3'b001, 1'b0);
    tick();
    repeat (5) tick();
    chk("disable_no_repeat", time_hours_out, 0);
    set_btn(5'b0);

    // Inactivity timeout after 20 edit cycles; values retained.
    enable = 1'b1;
    tick();
    tick();
    chk("timeout_entry", editing, 1);
    repeat (19) tick();
    chk("timeout_not_yet", editing, 1);
    tick();
    chk("timeout_exit", editing, 0);
    chk("timeout_keep_hours", time_hours_out, 23);
    chk("timeout_keep_minutes", time_minutes_out, 58);

    // Asynchronous reset mid-edit.
    tick();
    tick();
    chk("reedit", editing, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_editing", editing, 0);
    chk("areset_time", {time_hours_out, time_minutes_out}, 0);
    chk("areset_alarms", {alarm_hours_out, alarm_minutes_out}, 0);
    chk("areset_led", field_led, 0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
